// File: rtl/aurora_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aurora_pkg
// Purpose  : Shared types and constants for the Aurora TX packet scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package aurora_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    GAP   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [1:0] MODE_HOST = 2'b00;
  localparam logic [1:0] MODE_LOOP = 2'b01;
  localparam logic [1:0] MODE_RR   = 2'b10;
  localparam logic [1:0] MODE_HALT = 2'b11;

  localparam logic SRC_HOST = 1'b0;
  localparam logic SRC_LOOP = 1'b1;

  // True when the given mode allows the given source to compete for the lane.
  function automatic logic src_enabled(input logic [1:0] mode, input logic src);
    logic result;
    case (mode)
      MODE_HOST: result = (src == SRC_HOST);
      MODE_LOOP: result = (src == SRC_LOOP);
      MODE_RR:   result = 1'b1;
      default:   result = 1'b0;
    endcase
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aurora_tx_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : aurora_tx_rr_pick
// Purpose  : Combinational eligibility filter and round-robin grant selection.
// Revision : 1.0 - initial release
// ============================================================================
module aurora_tx_rr_pick
  import aurora_pkg::*;
(
  input  logic       i_enable,
  input  logic [1:0] i_mode,
  input  logic       i_req_host,
  input  logic       i_req_loop,
  input  logic       i_rr_ptr,
  output logic       o_grant_src,
  output logic       o_grant_vld
);

  logic w_elig_host;
  logic w_elig_loop;

  assign w_elig_host = i_enable && i_req_host && src_enabled(i_mode, SRC_HOST);
  assign w_elig_loop = i_enable && i_req_loop && src_enabled(i_mode, SRC_LOOP);

  // i_rr_ptr names the preferred source, i.e. the one not granted last time.
  always_comb begin
    o_grant_vld = 1'b0;
    o_grant_src = SRC_HOST;
    if (w_elig_host && w_elig_loop) begin
      o_grant_vld = 1'b1;
      o_grant_src = i_rr_ptr;
    end else if (w_elig_host) begin
      o_grant_vld = 1'b1;
      o_grant_src = SRC_HOST;
    end else if (w_elig_loop) begin
      o_grant_vld = 1'b1;
      o_grant_src = SRC_LOOP;
    end
  end

endmodule
`default_nettype wire

// File: rtl/aurora_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : aurora_tx_sched
// Purpose  : Packet-boundary scheduler sharing the Aurora TX lane between the
//            host stream and the loopback FIFO, with programmable gap and drain.
// Revision : 1.0 - initial release
// ============================================================================
module aurora_tx_sched
  import aurora_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int GAP_WIDTH  = 16
) (
  input  logic                  m_axis_aclk,
  input  logic                  sys_reset,
  input  logic                  channel_up,
  input  logic [1:0]            ctrl_mode,
  input  logic [GAP_WIDTH-1:0]  ctrl_gap,
  input  logic                  s0_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic                  s0_axis_tlast,
  output logic                  s0_axis_tready,
  input  logic                  s1_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic                  s1_axis_tlast,
  output logic                  s1_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  cur_src,
  output logic                  busy,
  output logic [31:0]           pkt_cnt_host,
  output logic [31:0]           pkt_cnt_loop,
  output logic [31:0]           drop_cnt
);

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   r_cur_src;
  logic                   r_rr_ptr;
  logic [GAP_WIDTH-1:0]   r_gap_cnt;
  logic [31:0]            r_pkt_cnt_host;
  logic [31:0]            r_pkt_cnt_loop;
  logic [31:0]            r_drop_cnt;

  logic                   w_grant_src;
  logic                   w_grant_vld;
  logic                   w_sel_tvalid;
  logic [DATA_WIDTH-1:0]  w_sel_tdata;
  logic                   w_sel_tlast;
  logic                   w_last_hs;
  logic                   w_drop_done;

  aurora_tx_rr_pick u_rr_pick (
    .i_enable    (channel_up),
    .i_mode      (ctrl_mode),
    .i_req_host  (s0_axis_tvalid),
    .i_req_loop  (s1_axis_tvalid),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant_src (w_grant_src),
    .o_grant_vld (w_grant_vld)
  );

  assign w_sel_tvalid = (r_cur_src == SRC_LOOP) ? s1_axis_tvalid : s0_axis_tvalid;
  assign w_sel_tdata  = (r_cur_src == SRC_LOOP) ? s1_axis_tdata  : s0_axis_tdata;
  assign w_sel_tlast  = (r_cur_src == SRC_LOOP) ? s1_axis_tlast  : s0_axis_tlast;

  // A completed last beat wins over a simultaneous channel drop.
  assign w_last_hs   = (r_state == XFER)  && w_sel_tvalid && m_axis_tready && w_sel_tlast;
  assign w_drop_done = (r_state == DRAIN) && w_sel_tvalid && w_sel_tlast;

  always_ff @(posedge m_axis_aclk or posedge sys_reset) begin
    if (sys_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_vld) begin
          w_state_next = XFER;
        end
      end
      XFER: begin
        if (w_last_hs) begin
          w_state_next = (ctrl_gap != '0) ? GAP : IDLE;
        end else if (!channel_up) begin
          w_state_next = DRAIN;
        end
      end
      GAP: begin
        if (r_gap_cnt <= GAP_WIDTH'(1)) begin
          w_state_next = IDLE;
        end
      end
      DRAIN: begin
        if (w_drop_done) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tlast   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    busy           = 1'b0;
    case (r_state)
      XFER: begin
        busy          = 1'b1;
        m_axis_tvalid = w_sel_tvalid;
        m_axis_tdata  = w_sel_tdata;
        m_axis_tlast  = w_sel_tlast;
        if (r_cur_src == SRC_LOOP) begin
          s1_axis_tready = m_axis_tready;
        end else begin
          s0_axis_tready = m_axis_tready;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (r_cur_src == SRC_LOOP) begin
          s1_axis_tready = 1'b1;
        end else begin
          s0_axis_tready = 1'b1;
        end
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge m_axis_aclk or posedge sys_reset) begin
    if (sys_reset) begin
      r_cur_src      <= SRC_HOST;
      r_rr_ptr       <= SRC_HOST;
      r_gap_cnt      <= '0;
      r_pkt_cnt_host <= '0;
      r_pkt_cnt_loop <= '0;
      r_drop_cnt     <= '0;
    end else begin
      if ((r_state == IDLE) && w_grant_vld) begin
        r_cur_src <= w_grant_src;
        r_rr_ptr  <= ~w_grant_src;
      end
      if (w_last_hs) begin
        r_gap_cnt <= ctrl_gap;
        if (r_cur_src == SRC_LOOP) begin
          r_pkt_cnt_loop <= r_pkt_cnt_loop + 32'd1;
        end else begin
          r_pkt_cnt_host <= r_pkt_cnt_host + 32'd1;
        end
      end else if (r_state == GAP) begin
        r_gap_cnt <= r_gap_cnt - GAP_WIDTH'(1);
      end
      if (w_drop_done) begin
        r_drop_cnt <= r_drop_cnt + 32'd1;
      end
    end
  end

  assign cur_src      = r_cur_src;
  assign pkt_cnt_host = r_pkt_cnt_host;
  assign pkt_cnt_loop = r_pkt_cnt_loop;
  assign drop_cnt     = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_aurora_tx_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_aurora_tx_sched
// Purpose  : Self-checking bench with packet-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aurora_tx_sched;

  localparam int DW = 32;
  localparam int GW = 16;

  logic          m_axis_aclk;
  logic          sys_reset;
  logic          channel_up;
  logic [1:0]    ctrl_mode;
  logic [GW-1:0] ctrl_gap;
  logic          s0_axis_tvalid, s0_axis_tlast, s0_axis_tready;
  logic [DW-1:0] s0_axis_tdata;
  logic          s1_axis_tvalid, s1_axis_tlast, s1_axis_tready;
  logic [DW-1:0] s1_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          cur_src, busy;
  logic [31:0]   pkt_cnt_host, pkt_cnt_loop, drop_cnt;

  aurora_tx_sched #(.DATA_WIDTH(DW), .GAP_WIDTH(GW)) dut (
    .m_axis_aclk(m_axis_aclk), .sys_reset(sys_reset), .channel_up(channel_up),
    .ctrl_mode(ctrl_mode), .ctrl_gap(ctrl_gap),
    .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tdata(s0_axis_tdata),
    .s0_axis_tlast(s0_axis_tlast), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tdata(s1_axis_tdata),
    .s1_axis_tlast(s1_axis_tlast), .s1_axis_tready(s1_axis_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .cur_src(cur_src), .busy(busy), .pkt_cnt_host(pkt_cnt_host),
    .pkt_cnt_loop(pkt_cnt_loop), .drop_cnt(drop_cnt)
  );

  initial m_axis_aclk = 1'b0;
  always #5 m_axis_aclk = ~m_axis_aclk;

  typedef struct packed { logic [31:0] data; logic last; } beat_t;
  typedef struct packed { logic [31:0] data; logic last; logic src; } exp_t;
  typedef struct { logic [31:0] data; logic last; logic src; int cyc; } mon_t;

  beat_t q0[$];
  beat_t q1[$];
  exp_t  exp_q[$];
  mon_t  mon_q[$];
  int    cyc;
  int    checks;
  int    failures;
  int    tr_mode;       // 0 ready always, 1 toggle, 2 random
  logic  s1_rdy_seen;
  logic  drain_watch;
  int    drain_stall;
  int    drain_mvalid;

  task automatic drive_sources();
    s0_axis_tvalid = (q0.size() > 0);
    s0_axis_tdata  = (q0.size() > 0) ? q0[0].data : '0;
    s0_axis_tlast  = (q0.size() > 0) ? q0[0].last : 1'b0;
    s1_axis_tvalid = (q1.size() > 0);
    s1_axis_tdata  = (q1.size() > 0) ? q1[0].data : '0;
    s1_axis_tlast  = (q1.size() > 0) ? q1[0].last : 1'b0;
  endtask

  task automatic add_pkt(input logic src, input int len, input bit expect_it);
    beat_t b;
    exp_t  e;
    for (int i = 0; i < len; i++) begin
      b.data = $urandom;
      b.last = (i == len - 1);
      if (src) q1.push_back(b); else q0.push_back(b);
      if (expect_it) begin
        e.data = b.data; e.last = b.last; e.src = src;
        exp_q.push_back(e);
      end
    end
    drive_sources();
  endtask

  // One clock: observe at the falling edge, advance sources just after the rising edge.
  task automatic cycle();
    logic f0, f1;
    @(negedge m_axis_aclk);
    f0 = s0_axis_tvalid & s0_axis_tready;
    f1 = s1_axis_tvalid & s1_axis_tready;
    if (m_axis_tvalid && m_axis_tready)
      mon_q.push_back('{m_axis_tdata, m_axis_tlast, cur_src, cyc});
    if (s1_axis_tready) s1_rdy_seen = 1'b1;
    if (drain_watch && s1_axis_tvalid && !s1_axis_tready) drain_stall++;
    if (drain_watch && m_axis_tvalid) drain_mvalid++;
    cyc++;
    @(posedge m_axis_aclk);
    #1;
    if (f0) void'(q0.pop_front());
    if (f1) void'(q1.pop_front());
    drive_sources();
    case (tr_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ~m_axis_tready;
      default: m_axis_tready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic do_reset();
    sys_reset = 1'b1;
    q0.delete(); q1.delete(); exp_q.delete(); mon_q.delete();
    drive_sources();
    channel_up = 1'b1; ctrl_mode = 2'b00; ctrl_gap = '0;
    tr_mode = 0; m_axis_tready = 1'b1;
    s1_rdy_seen = 1'b0; drain_watch = 1'b0; drain_stall = 0; drain_mvalid = 0;
    repeat (2) @(posedge m_axis_aclk);
    #1 sys_reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid: got %b expected 0", m_axis_tvalid); end
    checks++; if (m_axis_tlast !== 1'b0) begin failures++; $display("FAIL rst_tlast: got %b expected 0", m_axis_tlast); end
    checks++; if (s0_axis_tready !== 1'b0 || s1_axis_tready !== 1'b0) begin failures++; $display("FAIL rst_tready: got %b%b expected 00", s0_axis_tready, s1_axis_tready); end
    checks++; if (busy !== 1'b0 || cur_src !== 1'b0) begin failures++; $display("FAIL rst_busy_src: got %b%b expected 00", busy, cur_src); end
    checks++; if (pkt_cnt_host !== 32'd0 || pkt_cnt_loop !== 32'd0 || drop_cnt !== 32'd0) begin failures++; $display("FAIL rst_counters: got %0d/%0d/%0d expected 0/0/0", pkt_cnt_host, pkt_cnt_loop, drop_cnt); end
  endtask

  task automatic test_host_only();
    int c_valid;
    do_reset();
    c_valid = cyc;
    add_pkt(1'b0, 4, 1'b1);
    add_pkt(1'b1, 3, 1'b0);
    for (int k = 0; k < 40 && mon_q.size() < 4; k++) cycle();
    repeat (5) cycle();
    checks++; if (mon_q.size() == 0 || mon_q[0].cyc !== c_valid + 1) begin failures++; $display("FAIL host_grant_latency: got first beat cycle %0d expected %0d", (mon_q.size() > 0) ? mon_q[0].cyc : -1, c_valid + 1); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= mon_q.size()) begin failures++; $display("FAIL host_beat[%0d]: got none expected %08h", i, exp_q[i].data); end
      else if (mon_q[i].data !== exp_q[i].data || mon_q[i].last !== exp_q[i].last || mon_q[i].src !== exp_q[i].src) begin
        failures++; $display("FAIL host_beat[%0d]: got %08h/%b/%b expected %08h/%b/%b", i, mon_q[i].data, mon_q[i].last, mon_q[i].src, exp_q[i].data, exp_q[i].last, exp_q[i].src);
      end
    end
    checks++; if (mon_q.size() != 4) begin failures++; $display("FAIL host_beat_count: got %0d expected 4", mon_q.size()); end
    checks++; if (pkt_cnt_host !== 32'd1 || pkt_cnt_loop !== 32'd0) begin failures++; $display("FAIL host_counts: got %0d/%0d expected 1/0", pkt_cnt_host, pkt_cnt_loop); end
    checks++; if (s1_rdy_seen !== 1'b0) begin failures++; $display("FAIL host_s1_tready: got 1 expected 0"); end
  endtask

  task automatic test_round_robin();
    do_reset();
    ctrl_mode = 2'b10;
    ctrl_gap  = GW'($urandom_range(0, 3));
    tr_mode   = 2;
    for (int p = 0; p < 2; p++) begin
      add_pkt(1'b0, 3, 1'b1);
      add_pkt(1'b1, 3, 1'b1);
    end
    for (int k = 0; k < 200 && mon_q.size() < exp_q.size(); k++) cycle();
    repeat (8) cycle();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= mon_q.size()) begin failures++; $display("FAIL rr_beat[%0d]: got none expected %08h", i, exp_q[i].data); end
      else if (mon_q[i].data !== exp_q[i].data || mon_q[i].last !== exp_q[i].last || mon_q[i].src !== exp_q[i].src) begin
        failures++; $display("FAIL rr_beat[%0d]: got %08h/%b/%b expected %08h/%b/%b", i, mon_q[i].data, mon_q[i].last, mon_q[i].src, exp_q[i].data, exp_q[i].last, exp_q[i].src);
      end
    end
    checks++; if (pkt_cnt_host !== 32'd2 || pkt_cnt_loop !== 32'd2) begin failures++; $display("FAIL rr_counts: got %0d/%0d expected 2/2", pkt_cnt_host, pkt_cnt_loop); end
  endtask

  task automatic test_gap();
    int gaps[3];
    int l1;
    int idle;
    gaps[0] = 5; gaps[1] = 0; gaps[2] = $urandom_range(1, 10);
    for (int g = 0; g < 3; g++) begin
      do_reset();
      ctrl_gap = GW'(gaps[g]);
      l1 = $urandom_range(1, 4);
      add_pkt(1'b0, l1, 1'b1);
      add_pkt(1'b0, $urandom_range(1, 4), 1'b1);
      for (int k = 0; k < 60 && mon_q.size() < exp_q.size(); k++) cycle();
      checks++;
      if (mon_q.size() != exp_q.size()) begin
        failures++; $display("FAIL gap%0d_beats: got %0d expected %0d", gaps[g], mon_q.size(), exp_q.size());
      end else begin
        idle = mon_q[l1].cyc - mon_q[l1-1].cyc - 1;
        if (idle != gaps[g] + 1) begin failures++; $display("FAIL gap%0d_idle: got %0d idle cycles expected %0d", gaps[g], idle, gaps[g] + 1); end
      end
    end
  endtask

  task automatic test_drain();
    do_reset();
    ctrl_mode = 2'b01;
    add_pkt(1'b1, 8, 1'b1);
    for (int k = 0; k < 40 && mon_q.size() < 1; k++) cycle();
    channel_up = 1'b0;
    cycle();
    drain_watch = 1'b1;
    for (int k = 0; k < 40 && q1.size() > 0; k++) cycle();
    repeat (3) cycle();
    drain_watch = 1'b0;
    checks++; if (mon_q.size() != 2) begin failures++; $display("FAIL drain_beats_out: got %0d expected 2", mon_q.size()); end
    else begin
      checks++; if (mon_q[1].data !== exp_q[1].data) begin failures++; $display("FAIL drain_beat2: got %08h expected %08h", mon_q[1].data, exp_q[1].data); end
    end
    checks++; if (q1.size() != 0 || drain_stall != 0) begin failures++; $display("FAIL drain_accept: got %0d left, %0d stalls expected 0/0", q1.size(), drain_stall); end
    checks++; if (drain_mvalid != 0) begin failures++; $display("FAIL drain_mvalid: got %0d valid cycles expected 0", drain_mvalid); end
    checks++; if (drop_cnt !== 32'd1 || pkt_cnt_loop !== 32'd0) begin failures++; $display("FAIL drain_counts: got drop %0d loop %0d expected 1/0", drop_cnt, pkt_cnt_loop); end
    channel_up = 1'b1;
    mon_q.delete(); exp_q.delete();
    add_pkt(1'b1, 3, 1'b1);
    for (int k = 0; k < 40 && mon_q.size() < 3; k++) cycle();
    repeat (3) cycle();
    checks++; if (mon_q.size() != 3 || mon_q[2].data !== exp_q[2].data) begin failures++; $display("FAIL drain_recover: got %0d beats expected 3 intact", mon_q.size()); end
    checks++; if (pkt_cnt_loop !== 32'd1 || drop_cnt !== 32'd1) begin failures++; $display("FAIL drain_recover_counts: got loop %0d drop %0d expected 1/1", pkt_cnt_loop, drop_cnt); end
  endtask

  task automatic test_mode_change();
    do_reset();
    tr_mode = 1;
    add_pkt(1'b0, $urandom_range(4, 6), 1'b1);
    add_pkt(1'b1, 4, 1'b1);
    add_pkt(1'b0, 2, 1'b0);
    for (int k = 0; k < 40 && mon_q.size() < 1; k++) cycle();
    ctrl_mode = 2'b01;
    for (int k = 0; k < 100 && mon_q.size() < exp_q.size(); k++) cycle();
    repeat (20) cycle();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= mon_q.size()) begin failures++; $display("FAIL mode_beat[%0d]: got none expected %08h", i, exp_q[i].data); end
      else if (mon_q[i].data !== exp_q[i].data || mon_q[i].last !== exp_q[i].last || mon_q[i].src !== exp_q[i].src) begin
        failures++; $display("FAIL mode_beat[%0d]: got %08h/%b/%b expected %08h/%b/%b", i, mon_q[i].data, mon_q[i].last, mon_q[i].src, exp_q[i].data, exp_q[i].last, exp_q[i].src);
      end
    end
    checks++; if (mon_q.size() != exp_q.size()) begin failures++; $display("FAIL mode_beat_count: got %0d expected %0d", mon_q.size(), exp_q.size()); end
    checks++; if (pkt_cnt_host !== 32'd1 || pkt_cnt_loop !== 32'd1 || q0.size() != 2) begin failures++; $display("FAIL mode_counts: got %0d/%0d pending %0d expected 1/1/2", pkt_cnt_host, pkt_cnt_loop, q0.size()); end
  endtask

  task automatic test_halt();
    do_reset();
    ctrl_mode = 2'b11;
    add_pkt(1'b0, 3, 1'b1);
    add_pkt(1'b1, 2, 1'b0);
    repeat (10) cycle();
    checks++; if (mon_q.size() != 0 || busy !== 1'b0) begin failures++; $display("FAIL halt_no_grant: got %0d beats busy %b expected 0/0", mon_q.size(), busy); end
    ctrl_mode = 2'b00;
    channel_up = 1'b0;
    repeat (10) cycle();
    checks++; if (mon_q.size() != 0 || busy !== 1'b0) begin failures++; $display("FAIL down_no_grant: got %0d beats busy %b expected 0/0", mon_q.size(), busy); end
    channel_up = 1'b1;
    for (int k = 0; k < 40 && mon_q.size() < 3; k++) cycle();
    repeat (3) cycle();
    checks++; if (mon_q.size() != 3 || mon_q[0].data !== exp_q[0].data || pkt_cnt_host !== 32'd1) begin failures++; $display("FAIL halt_resume: got %0d beats host cnt %0d expected 3/1", mon_q.size(), pkt_cnt_host); end
  endtask

  task automatic test_async_reset();
    do_reset();
    ctrl_mode = 2'b01;
    add_pkt(1'b1, 3, 1'b1);
    add_pkt(1'b1, 8, 1'b1);
    for (int k = 0; k < 40 && mon_q.size() < 5; k++) cycle();
    checks++; if (pkt_cnt_loop !== 32'd1 || cur_src !== 1'b1 || busy !== 1'b1 || m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL arst_pre: got cnt %0d src %b busy %b valid %b expected 1/1/1/1", pkt_cnt_loop, cur_src, busy, m_axis_tvalid); end
    #2 sys_reset = 1'b1;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || s1_axis_tready !== 1'b0 || s0_axis_tready !== 1'b0) begin failures++; $display("FAIL arst_stream: got valid %b last %b rdy %b%b expected 0/0/00", m_axis_tvalid, m_axis_tlast, s0_axis_tready, s1_axis_tready); end
    checks++; if (busy !== 1'b0 || cur_src !== 1'b0 || pkt_cnt_loop !== 32'd0) begin failures++; $display("FAIL arst_state: got busy %b src %b cnt %0d expected 0/0/0", busy, cur_src, pkt_cnt_loop); end
    q0.delete(); q1.delete(); exp_q.delete(); mon_q.delete();
    drive_sources();
    @(posedge m_axis_aclk);
    #1 sys_reset = 1'b0;
    repeat (3) cycle();
    checks++; if (busy !== 1'b0 || m_axis_tvalid !== 1'b0 || pkt_cnt_host !== 32'd0 || pkt_cnt_loop !== 32'd0 || drop_cnt !== 32'd0) begin failures++; $display("FAIL arst_post: got busy %b valid %b counts %0d/%0d/%0d expected idle and 0", busy, m_axis_tvalid, pkt_cnt_host, pkt_cnt_loop, drop_cnt); end
    add_pkt(1'b1, 2, 1'b1);
    for (int k = 0; k < 40 && mon_q.size() < 2; k++) cycle();
    repeat (2) cycle();
    checks++; if (mon_q.size() != 2 || pkt_cnt_loop !== 32'd1) begin failures++; $display("FAIL arst_resume: got %0d beats cnt %0d expected 2/1", mon_q.size(), pkt_cnt_loop); end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    sys_reset = 1'b1; channel_up = 1'b0; ctrl_mode = 2'b00; ctrl_gap = '0;
    m_axis_tready = 1'b0; tr_mode = 0;
    drive_sources();
    test_reset();
    test_host_only();
    test_round_robin();
    test_gap();
    test_drain();
    test_mode_change();
    test_halt();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
